cursor_position: RTL
====================

CURSOR_POSITION -- requirements
Module: cursor_position

Interface
REQ-001 SHALL have parameter COLS, default 80, the number of text columns.
REQ-002 SHALL have parameter ROWS, default 24, the number of text rows.
REQ-003 SHALL have port clk  input  1  single clock for all logic.
REQ-004 SHALL have port clr  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port cmd  input  4  cursor command code.
REQ-006 SHALL have port cmd_valid  input  1  cmd is valid this cycle.
REQ-007 SHALL have port cmd_ready  output  1  a command is accepted when cmd_valid and cmd_ready are both high.
REQ-008 SHALL have ports set_row and set_col  input  5 and 7  target row and column for the SET command.
REQ-009 SHALL have ports cursor_y and cursor_x  output  5 and 7  current cursor row and column.
REQ-010 SHALL have port scroll_req  output  1  request to scroll the screen up by one line.
REQ-011 SHALL have port scroll_ack  input  1  the scroller has completed the request.
REQ-012 SHALL have port moved  output  1  one-cycle pulse on a position change; drives the blink-counter synchronous reset.

Function
REQ-013 SHALL implement the commands NOP, UP, DOWN, LEFT, RIGHT, HOME, CR, LF, SET and ADVANCE; undefined codes SHALL be treated as NOP.
REQ-014 UP, DOWN, LEFT and RIGHT SHALL move one cell and saturate at the screen edges (row 0 / ROWS-1, column 0 / COLS-1); no wrap and no scroll.
REQ-015 HOME SHALL set the position to (0,0).
REQ-016 CR SHALL set the column to 0 and leave the row unchanged.
REQ-017 LF at a row below ROWS-1 SHALL increment the row.
REQ-018 LF at row ROWS-1 SHALL enter the SCROLL state with the row unchanged.
REQ-019 SET SHALL load set_row and set_col, each clamped independently to ROWS-1 and COLS-1.
REQ-020 ADVANCE (the character was written) SHALL behave as RIGHT unless CURSOR_AUTOWRAP_EN is defined (see REQ-031).
REQ-021 The state machine SHALL have two states:
- IDLE: cmd_ready=1.
- SCROLL: cmd_ready=0, scroll_req=1.
REQ-022 Transitions SHALL be: IDLE->SCROLL on an accepted command that requires a scroll; SCROLL->IDLE in the cycle scroll_ack is sampled high.
REQ-023 The position update SHALL take effect on the clock edge that accepts the command (latency 1 cycle).
REQ-024 moved SHALL be high in the cycle after the update edge only if (cursor_x, cursor_y) changed.
REQ-025 Saturated moves and NOPs SHALL NOT pulse moved.
REQ-026 Scroll completion SHALL pulse moved for one cycle, because the cell under the cursor changed.
REQ-027 scroll_ack while in IDLE SHALL be ignored.
REQ-028 cmd_valid while in SCROLL SHALL NOT be accepted; the command SHALL be held by the producer.
REQ-029 All arithmetic SHALL be unsigned at the port widths; no intermediate overflow is permitted (compare before increment and decrement).

Reset
REQ-030 Asserting clr SHALL asynchronously force, even mid-scroll: state IDLE, cursor_x=0, cursor_y=0, scroll_req=0, moved=0, cmd_ready=1 (once clr is released).

Configuration
REQ-031 With CURSOR_AUTOWRAP_EN defined, ADVANCE at column COLS-1 SHALL set the column to 0 and behave as LF for the row, including the scroll at the last row.
REQ-032 With CURSOR_AUTOWRAP_EN undefined, ADVANCE at column COLS-1 SHALL hold the column with no moved pulse (VT52 behaviour).

Structure
REQ-033 Shared package cursor_pkg SHALL hold the command code constants (NOP=0 through ADVANCE=9), the state encoding, and the default COLS/ROWS.
REQ-034 The block SHALL be a single module; no sub-module is natural.

Verification
REQ-035 Reset, then RIGHT x3, then DOWN x2 -> cursor_x=3, cursor_y=2; five moved pulses, each one cycle after its accept.
REQ-036 At (0,0), UP then LEFT -> position stays (0,0); moved stays low; cmd_ready stays 1.
REQ-037 SET row=30, col=100 -> position (23,79); one moved pulse.
REQ-038 At row 23, LF -> scroll_req=1, cmd_ready=0; hold scroll_ack=0 for 10 cycles with cmd_valid=1 -> no accept; scroll_ack=1 -> IDLE next cycle; one moved pulse; row remains 23.
REQ-039 At (5,79), ADVANCE -> without the macro: (5,79) and no moved pulse; with CURSOR_AUTOWRAP_EN: (6,0) and a moved pulse.
REQ-040 Assert clr during SCROLL -> scroll_req drops immediately; position (0,0); cmd_ready=1 once clr is released.

Source files
------------

// File: rtl/cursor_pkg.sv
// rtl/cursor_pkg.sv - command codes, FSM state encoding and default screen size for cursor_position
package cursor_pkg;

    localparam int DEFAULT_COLS = 80;
    localparam int DEFAULT_ROWS = 24;

    localparam logic [3:0] CMD_NOP     = 4'd0;
    localparam logic [3:0] CMD_UP      = 4'd1;
    localparam logic [3:0] CMD_DOWN    = 4'd2;
    localparam logic [3:0] CMD_LEFT    = 4'd3;
    localparam logic [3:0] CMD_RIGHT   = 4'd4;
    localparam logic [3:0] CMD_HOME    = 4'd5;
    localparam logic [3:0] CMD_CR      = 4'd6;
    localparam logic [3:0] CMD_LF      = 4'd7;
    localparam logic [3:0] CMD_SET     = 4'd8;
    localparam logic [3:0] CMD_ADVANCE = 4'd9;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_SCROLL = 1'b1
    } cursor_state_t;

endpackage

// File: rtl/cursor_position.sv
// rtl/cursor_position.sv - text cursor position tracker with scroll handshake
//
// Optional feature macro: CURSOR_AUTOWRAP_EN (ADVANCE at the last column wraps
// to column 0 and line-feeds, scrolling at the last row). Undefined: ADVANCE
// saturates at the last column like RIGHT.
//
// Ports:
//   clk        clock
//   clr        asynchronous active-high reset
//   cmd        [3:0] command code (undefined codes act as NOP)
//   cmd_valid  command present
//   cmd_ready  high in IDLE; command accepted when cmd_valid && cmd_ready
//   set_row    [4:0] target row for SET (clamped to ROWS-1)
//   set_col    [6:0] target column for SET (clamped to COLS-1)
//   cursor_y   [4:0] current row
//   cursor_x   [6:0] current column
//   scroll_req request to scroll the screen up one line (high in SCROLL)
//   scroll_ack scroller completion, only honoured in SCROLL
//   moved      one-cycle pulse after a position change or scroll completion
module cursor_position #(
    parameter int COLS = cursor_pkg::DEFAULT_COLS,
    parameter int ROWS = cursor_pkg::DEFAULT_ROWS
) (
    input  logic       clk,
    input  logic       clr,
    input  logic [3:0] cmd,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [4:0] set_row,
    input  logic [6:0] set_col,
    output logic [4:0] cursor_y,
    output logic [6:0] cursor_x,
    output logic       scroll_req,
    input  logic       scroll_ack,
    output logic       moved
);
    import cursor_pkg::*;

    localparam logic [4:0] MAX_ROW = 5'(ROWS - 1);
    localparam logic [6:0] MAX_COL = 7'(COLS - 1);

    cursor_state_t state, next_state;
    logic [4:0]    next_y;
    logic [6:0]    next_x;
    logic          moved_d;

    // Handshake outputs decode straight from state so clr removes scroll_req
    // without waiting for a clock edge.
    assign cmd_ready  = (state == ST_IDLE);
    assign scroll_req = (state == ST_SCROLL);

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state    <= ST_IDLE;
            cursor_x <= 7'd0;
            cursor_y <= 5'd0;
            moved    <= 1'b0;
        end else begin
            state    <= next_state;
            cursor_x <= next_x;
            cursor_y <= next_y;
            moved    <= moved_d;
        end
    end

    always_comb begin
        next_state = state;
        next_x     = cursor_x;
        next_y     = cursor_y;
        moved_d    = 1'b0;

        case (state)
            ST_IDLE: begin
                if (cmd_valid) begin
                    // Every bound is checked before the +/-1 so the 5/7-bit
                    // registers never wrap.
                    case (cmd)
                        CMD_UP:    if (cursor_y != 5'd0)  next_y = cursor_y - 5'd1;
                        CMD_DOWN:  if (cursor_y < MAX_ROW) next_y = cursor_y + 5'd1;
                        CMD_LEFT:  if (cursor_x != 7'd0)  next_x = cursor_x - 7'd1;
                        CMD_RIGHT: if (cursor_x < MAX_COL) next_x = cursor_x + 7'd1;
                        CMD_HOME: begin
                            next_x = 7'd0;
                            next_y = 5'd0;
                        end
                        CMD_CR:    next_x = 7'd0;
                        CMD_LF: begin
                            if (cursor_y < MAX_ROW) next_y = cursor_y + 5'd1;
                            else                    next_state = ST_SCROLL;
                        end
                        CMD_SET: begin
                            next_y = (set_row > MAX_ROW) ? MAX_ROW : set_row;
                            next_x = (set_col > MAX_COL) ? MAX_COL : set_col;
                        end
                        CMD_ADVANCE: begin
`ifdef CURSOR_AUTOWRAP_EN
                            if (cursor_x < MAX_COL) begin
                                next_x = cursor_x + 7'd1;
                            end else begin
                                next_x = 7'd0;
                                if (cursor_y < MAX_ROW) next_y = cursor_y + 5'd1;
                                else                    next_state = ST_SCROLL;
                            end
`else
                            if (cursor_x < MAX_COL) next_x = cursor_x + 7'd1;
`endif
                        end
                        default: ;
                    endcase
                    moved_d = (next_x != cursor_x) || (next_y != cursor_y);
                end
            end
            ST_SCROLL: begin
                // The row stays put but the text under it changed, so the
                // blink counter is restarted on completion.
                if (scroll_ack) begin
                    next_state = ST_IDLE;
                    moved_d    = 1'b1;
                end
            end
            default: next_state = ST_IDLE;
        endcase
    end

endmodule
